// File: rtl/tdm_pkg.sv
// tdm_pkg: types and defaults shared by the TDM receive path.
//   tdm_state_t  : lock state machine encoding (HUNT / RUN)
//   TDM_NUM_CH   : default number of channels per frame
//   TDM_CH_W     : default bits per channel word
//   frame_bits() : total serial bits in one frame
package tdm_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } tdm_state_t;

  localparam int TDM_NUM_CH = 4;
  localparam int TDM_CH_W   = 8;

  function automatic int frame_bits(input int n, input int w);
    return n * w;
  endfunction

endpackage

// File: rtl/tdm_frame_counter.sv
// tdm_frame_counter: bit-within-channel and channel-within-frame position
// counters for the TDM receiver.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   clr_i          : force both counters to 0 (highest priority)
//   load1_i        : position after a frame's first bit (bit 1 of ch 0)
//   adv_i          : advance one bit position, wrapping at channel/frame end
//   ch_cnt_o       : current channel index
//   last_bit_o     : current position is the final bit of the frame
//   frame_start_o  : current position is the first bit of a frame
module tdm_frame_counter
  import tdm_pkg::*;
#(
  parameter int NUM_CH = TDM_NUM_CH,
  parameter int CH_W   = TDM_CH_W
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clr_i,
  input  logic                      load1_i,
  input  logic                      adv_i,
  output logic [$clog2(NUM_CH)-1:0] ch_cnt_o,
  output logic                      last_bit_o,
  output logic                      frame_start_o
);

  localparam int BW = $clog2(CH_W);
  localparam int CW = $clog2(NUM_CH);
  localparam logic [BW-1:0] BIT_LAST = BW'(CH_W - 1);
  localparam logic [CW-1:0] CH_LAST  = CW'(NUM_CH - 1);

  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [CW-1:0] ch_cnt_q, ch_cnt_d;

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    ch_cnt_d  = ch_cnt_q;
    if (clr_i) begin
      bit_cnt_d = '0;
      ch_cnt_d  = '0;
    end else if (load1_i) begin
      bit_cnt_d = BW'(1);
      ch_cnt_d  = '0;
    end else if (adv_i) begin
      if (bit_cnt_q == BIT_LAST) begin
        bit_cnt_d = '0;
        ch_cnt_d  = (ch_cnt_q == CH_LAST) ? '0 : ch_cnt_q + CW'(1);
      end else begin
        bit_cnt_d = bit_cnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bit_cnt_q <= '0;
      ch_cnt_q  <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      ch_cnt_q  <= ch_cnt_d;
    end
  end

  assign ch_cnt_o      = ch_cnt_q;
  assign last_bit_o    = (ch_cnt_q == CH_LAST) && (bit_cnt_q == BIT_LAST);
  assign frame_start_o = (ch_cnt_q == '0) && (bit_cnt_q == '0);

endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: receive end of a TDM serial link. Serial bits (MSB of each
// channel first) are shifted into a shadow frame register; a completed frame
// is copied to ch_data in one step so downstream logic never sees a mix of
// two frames.
// Ports:
//   clk, resetn  : clock (rising edge), asynchronous active-low reset
//   bit_en       : bit strobe; serial_in/frame_sync only sampled when high
//   serial_in    : serial data
//   frame_sync   : high with the first bit (ch0 MSB) of every frame
//   ch_data      : channel words, ch k at [k*CH_W +: CH_W]
//   frame_valid  : one-cycle pulse when ch_data takes a new frame
//   locked       : high while the lock FSM is in RUN (mirrors the FSM state)
//   sync_err     : one-cycle pulse on a framing error
// Handshake: there is no back-pressure. A bit is transferred on every rising
// edge with bit_en=1; frame_valid/sync_err are single-cycle strobes that the
// consumer must take on the cycle they are high.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int NUM_CH = TDM_NUM_CH,
  parameter int CH_W   = TDM_CH_W
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     bit_en,
  input  logic                     serial_in,
  input  logic                     frame_sync,
  output logic [NUM_CH*CH_W-1:0]   ch_data,
  output logic                     frame_valid,
  output logic                     locked,
  output logic                     sync_err
);

  localparam int FW = frame_bits(NUM_CH, CH_W);
  localparam int CW = $clog2(NUM_CH);

  tdm_state_t    state_q, state_d;
  logic [FW-1:0] shadow_q, shadow_d;
  logic [FW-1:0] ch_data_q, ch_data_d;
  logic          frame_valid_q, frame_valid_d;
  logic          sync_err_q, sync_err_d;

  logic          cnt_clr, cnt_load1, cnt_adv;
  logic [CW-1:0] ch_cnt;
  logic          last_bit, frame_start;
  logic          shift_en;
  logic [CW-1:0] shift_ch;

  tdm_frame_counter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_cnt (
    .clk_i         (clk),
    .rst_ni        (resetn),
    .clr_i         (cnt_clr),
    .load1_i       (cnt_load1),
    .adv_i         (cnt_adv),
    .ch_cnt_o      (ch_cnt),
    .last_bit_o    (last_bit),
    .frame_start_o (frame_start)
  );

  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    ch_data_d     = ch_data_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    cnt_clr       = 1'b0;
    cnt_load1     = 1'b0;
    cnt_adv       = 1'b0;
    shift_en      = 1'b0;
    shift_ch      = ch_cnt;

    case (state_q)
      HUNT: begin
        if (bit_en && frame_sync) begin
          shift_en  = 1'b1;
          shift_ch  = '0;
          cnt_load1 = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (bit_en) begin
          if (frame_sync && !frame_start) begin
            // Early sync (including on the last bit): drop the partial frame
            // and restart as ch0 MSB without losing lock.
            sync_err_d = 1'b1;
            shift_en   = 1'b1;
            shift_ch   = '0;
            cnt_load1  = 1'b1;
          end else if (!frame_sync && frame_start) begin
            // Missing sync: lose lock; ch_data keeps the last good frame.
            sync_err_d = 1'b1;
            cnt_clr    = 1'b1;
            state_d    = HUNT;
          end else begin
            shift_en = 1'b1;
            cnt_adv  = 1'b1;
            if (last_bit) begin
              frame_valid_d = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = HUNT;
        cnt_clr = 1'b1;
      end
    endcase

    // Left-shift the selected channel word, new bit at LSB. Stale bits from
    // an aborted frame fall out after CH_W shifts.
    for (int k = 0; k < NUM_CH; k++) begin
      if (shift_en && (shift_ch == CW'(k))) begin
        shadow_d[k*CH_W +: CH_W] = {shadow_q[k*CH_W +: CH_W-1], serial_in};
      end
    end

    // Publish on the same edge that samples the final bit, so the copy must
    // come from the already-shifted shadow.
    if (frame_valid_d) begin
      ch_data_d = shadow_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= HUNT;
      shadow_q      <= '0;
      ch_data_q     <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      ch_data_q     <= ch_data_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign ch_data     = ch_data_q;
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;
  assign locked      = (state_q == RUN);

endmodule

// File: tb/tb_tdm_demux.sv
module tb_tdm_demux;

  localparam logic [31:0] W1 = 32'h01FF3CA5;
  localparam logic [31:0] W2 = 32'h44332211;
  localparam logic [31:0] W3 = 32'h0D0C0B0A;

  logic        clk;
  logic        resetn;
  logic        bit_en;
  logic        serial_in;
  logic        frame_sync;
  logic [31:0] ch_data;
  logic        frame_valid;
  logic        locked;
  logic        sync_err;

  int n_tests = 0;
  int n_fail  = 0;
  int fv_cnt  = 0;
  int se_cnt  = 0;
  int fv_base;
  int se_base;

  tdm_demux #(
    .NUM_CH (4),
    .CH_W   (8)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .bit_en      (bit_en),
    .serial_in   (serial_in),
    .frame_sync  (frame_sync),
    .ch_data     (ch_data),
    .frame_valid (frame_valid),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pulse monitor: counts high cycles of each strobe
  always @(negedge clk) begin
    if (frame_valid) fv_cnt++;
    if (sync_err)    se_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    resetn     = 1'b0;
    bit_en     = 1'b0;
    serial_in  = 1'b0;
    frame_sync = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    fv_base = fv_cnt;
    se_base = se_cnt;
  endtask

  task automatic idle(input int n);
    bit_en     = 1'b0;
    frame_sync = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // gap idle cycles precede the bit so the check after the last bit of a
  // frame lands on the cycle where frame_valid is high
  task automatic send_bit(input logic b, input logic fs, input int gap);
    if (gap > 0) begin
      bit_en = 1'b0;
      repeat (gap) @(negedge clk);
    end
    bit_en     = 1'b1;
    serial_in  = b;
    frame_sync = fs;
    @(negedge clk);
  endtask

  // frame bit index i: channel i/8, MSB first
  task automatic send_range(input logic [31:0] w, input int from, input int to,
                            input int sync_idx, input int gap);
    for (int i = from; i <= to; i++) begin
      int ch;
      int b;
      ch = i / 8;
      b  = 7 - (i % 8);
      send_bit(w[ch*8 + b], (i == sync_idx), gap);
    end
  endtask

  initial begin
    // 1: reset state, single frame
    do_reset();
    check("rst_ch_data", ch_data, 0);
    check("rst_fv", frame_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_se", sync_err, 0);
    send_range(W1, 0, 0, 0, 0);
    check("t1_locked_first_bit", locked, 1);
    check("t1_fv_early", frame_valid, 0);
    send_range(W1, 1, 30, 0, 0);
    check("t1_fv_bit31", frame_valid, 0);
    send_range(W1, 31, 31, 0, 0);
    check("t1_fv", frame_valid, 1);
    check("t1_ch_data", ch_data, W1);
    idle(1);
    check("t1_fv_drop", frame_valid, 0);
    check("t1_fv_count", fv_cnt - fv_base, 1);
    check("t1_se_count", se_cnt - se_base, 0);

    // 2: back-to-back frames, bit_en 1 of 3 cycles
    do_reset();
    send_range(W1, 0, 31, 0, 2);
    check("t2_fv_a", frame_valid, 1);
    check("t2_ch_data_a", ch_data, W1);
    send_range(W2, 0, 31, 0, 2);
    check("t2_fv_b", frame_valid, 1);
    check("t2_ch_data_b", ch_data, W2);
    idle(3);
    check("t2_fv_count", fv_cnt - fv_base, 2);
    check("t2_se_count", se_cnt - se_base, 0);

    // 3: no sync before lock, then a valid frame
    do_reset();
    send_range(W2, 0, 9, -1, 0);
    check("t3_locked_nosync", locked, 0);
    check("t3_ch_data_nosync", ch_data, 0);
    idle(1);
    send_range(W1, 0, 31, 0, 0);
    check("t3_ch_data", ch_data, W1);
    idle(1);
    check("t3_fv_count", fv_cnt - fv_base, 1);

    // 4: early sync on bit 13 of the second frame
    do_reset();
    send_range(W1, 0, 31, 0, 0);
    send_range(W2, 0, 11, 0, 0);
    send_range(W3, 0, 0, 0, 0);
    check("t4_se_pulse", sync_err, 1);
    check("t4_locked", locked, 1);
    check("t4_ch_data_hold", ch_data, W1);
    send_range(W3, 1, 31, 0, 0);
    check("t4_fv", frame_valid, 1);
    check("t4_ch_data", ch_data, W3);
    idle(1);
    check("t4_fv_count", fv_cnt - fv_base, 2);
    check("t4_se_count", se_cnt - se_base, 1);

    // 5: missing sync at frame start, then relock
    do_reset();
    send_range(W1, 0, 31, 0, 0);
    send_bit(1'b1, 1'b0, 0);
    check("t5_se_pulse", sync_err, 1);
    check("t5_unlocked", locked, 0);
    check("t5_ch_data_hold", ch_data, W1);
    idle(1);
    check("t5_se_drop", sync_err, 0);
    send_range(W2, 0, 0, 0, 0);
    check("t5_relocked", locked, 1);
    send_range(W2, 1, 31, 0, 0);
    check("t5_ch_data", ch_data, W2);
    idle(1);
    check("t5_se_count", se_cnt - se_base, 1);
    check("t5_fv_count", fv_cnt - fv_base, 2);

    // 6: asynchronous reset mid-frame
    do_reset();
    send_range(W1, 0, 31, 0, 0);
    send_range(W2, 0, 19, 0, 0);
    bit_en = 1'b0;
    #2 resetn = 1'b0;
    #1;
    check("t6_rst_ch_data", ch_data, 0);
    check("t6_rst_locked", locked, 0);
    check("t6_rst_fv", frame_valid, 0);
    @(negedge clk);
    resetn  = 1'b1;
    fv_base = fv_cnt;
    send_range(W2, 0, 31, -1, 0);
    idle(2);
    check("t6_no_fv", fv_cnt - fv_base, 0);
    check("t6_locked", locked, 0);
    check("t6_ch_data", ch_data, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
